// File: rtl/led_seq_ctrl.sv
// LED sequencer with an Avalon-MM register file: static, rotate-left, rotate-right and blink modes
// stepped by a programmable prescaler. Optional step interrupt is built when LED_SEQ_IRQ_EN is defined.
module led_seq_ctrl #(
    parameter int                LED_W      = 18,
    parameter int                CNT_W      = 24,
    parameter logic [CNT_W-1:0]  PERIOD_RST = 24'd5000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [LED_W-1:0] out_port
`ifdef LED_SEQ_IRQ_EN
    ,
    output logic             irq
`endif
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_ROTL   = 2'b01,
        MODE_ROTR   = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_t;

    localparam logic [1:0] ADDR_PATTERN = 2'd0;
    localparam logic [1:0] ADDR_PERIOD  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    state_t             r_state;
    logic [LED_W-1:0]   r_pattern;
    logic [CNT_W-1:0]   r_period;
    logic               r_run;
    mode_t              r_mode;
    logic               r_step;
    logic [15:0]        r_step_cnt;
    logic [CNT_W-1:0]   r_presc;
    logic               r_phase;

    state_t             w_state_next;
    logic               w_wr;
    logic               w_wr_pattern;
    logic               w_wr_period;
    logic               w_wr_control;
    logic               w_wr_status;
    logic               w_run_next;
    mode_t              w_mode_next;
    logic [CNT_W-1:0]   w_period_eff;
    logic               w_terminal;
    logic               w_step;
    logic [CNT_W-1:0]   w_presc_next;
    logic [LED_W-1:0]   w_pattern_next;
    logic               w_phase_next;
    logic               w_step_next;
    logic [15:0]        w_step_cnt_next;
    logic [LED_W-1:0]   w_out_next;
    logic               w_irq_en;
    logic               w_unused;

    assign w_wr         = chipselect && !write_n;
    assign w_wr_pattern = w_wr && (address == ADDR_PATTERN);
    assign w_wr_period  = w_wr && (address == ADDR_PERIOD);
    assign w_wr_control = w_wr && (address == ADDR_CONTROL);
    assign w_wr_status  = w_wr && (address == ADDR_STATUS);

    assign w_run_next  = w_wr_control ? writedata[0] : r_run;
    assign w_mode_next = w_wr_control ? mode_t'(writedata[2:1]) : r_mode;

    // A zero period is treated as one so the sequencer still steps every cycle.
    assign w_period_eff = (r_period == '0) ? CNT_W'(1) : r_period;
    assign w_terminal   = (r_presc == (w_period_eff - CNT_W'(1)));
    // A PATTERN or PERIOD write in the terminal cycle suppresses the step entirely.
    assign w_step       = (r_state == ST_RUN) && w_terminal && !w_wr_pattern && !w_wr_period;

    // Only the low data bits are stored; the rest are ignored by design.
    assign w_unused = &{1'b0, writedata};

`ifdef LED_SEQ_IRQ_EN
    logic r_irq_en;
    logic w_irq_en_next;

    assign w_irq_en      = r_irq_en;
    assign w_irq_en_next = w_wr_control ? writedata[3] : r_irq_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_en <= 1'b0;
            irq      <= 1'b0;
        end else begin
            r_irq_en <= w_irq_en_next;
            irq      <= w_step_next && w_irq_en_next;
        end
    end
`else
    assign w_irq_en = 1'b0;
`endif

    // FSM next-state: the state tracks the RUN bit on the edge it is written.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_run_next)  w_state_next = ST_RUN;
            ST_RUN:  if (!w_run_next) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: every signal gets its default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        w_presc_next    = r_presc;
        w_pattern_next  = r_pattern;
        w_phase_next    = r_phase;
        w_step_next     = r_step;
        w_step_cnt_next = r_step_cnt;

        if (r_state == ST_RUN) begin
            w_presc_next = w_terminal ? '0 : r_presc + CNT_W'(1);
        end

        if (w_step) begin
            w_step_cnt_next = r_step_cnt + 16'd1;
            case (r_mode)
                MODE_ROTL:  w_pattern_next = {r_pattern[LED_W-2:0], r_pattern[LED_W-1]};
                MODE_ROTR:  w_pattern_next = {r_pattern[0], r_pattern[LED_W-1:1]};
                MODE_BLINK: w_phase_next   = ~r_phase;
                default:    w_pattern_next = r_pattern;
            endcase
        end

        if (w_wr_pattern) begin
            w_pattern_next = writedata[LED_W-1:0];
            w_phase_next   = 1'b0;
        end
        if (w_wr_pattern || w_wr_period) begin
            w_presc_next = '0;
        end
        if (w_state_next == ST_IDLE) begin
            w_presc_next = '0;
            w_phase_next = 1'b0;
        end

        // Set wins over a simultaneous write-1-to-clear.
        if (w_wr_status && writedata[1]) begin
            w_step_next = 1'b0;
        end
        if (w_step) begin
            w_step_next = 1'b1;
        end
    end

    assign w_out_next = ((w_mode_next == MODE_BLINK) && w_phase_next) ? '0 : w_pattern_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pattern  <= '0;
            r_period   <= PERIOD_RST;
            r_run      <= 1'b0;
            r_mode     <= MODE_STATIC;
            r_step     <= 1'b0;
            r_step_cnt <= '0;
            r_presc    <= '0;
            r_phase    <= 1'b0;
            out_port   <= '0;
        end else begin
            if (w_wr_period) begin
                r_period <= writedata[CNT_W-1:0];
            end
            r_pattern  <= w_pattern_next;
            r_run      <= w_run_next;
            r_mode     <= w_mode_next;
            r_step     <= w_step_next;
            r_step_cnt <= w_step_cnt_next;
            r_presc    <= w_presc_next;
            r_phase    <= w_phase_next;
            out_port   <= w_out_next;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_PATTERN: readdata = 32'(r_pattern);
            ADDR_PERIOD:  readdata = 32'(r_period);
            ADDR_CONTROL: readdata = {28'd0, w_irq_en, r_mode, r_run};
            ADDR_STATUS:  readdata = {r_step_cnt, 14'd0, r_step, (r_state == ST_RUN)};
            default:      readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl: expected out_port values are queued per cycle from a
// rotation/blink model and popped as the DUT produces them; register reads are checked inline.
module tb_led_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [17:0] out_port;
`ifdef LED_SEQ_IRQ_EN
    logic        irq;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [17:0] exp_q[$];

    always #5 clk = ~clk;

    led_seq_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
`ifdef LED_SEQ_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [17:0] rotl(input logic [17:0] v, input int n);
        logic [17:0] r = v;
        for (int i = 0; i < n; i++) r = {r[16:0], r[17]};
        return r;
    endfunction

    function automatic logic [17:0] rotr(input logic [17:0] v, input int n);
        logic [17:0] r = v;
        for (int i = 0; i < n; i++) r = {r[0], r[17:1]};
        return r;
    endfunction

    // Leaves the caller 1ns after a rising edge.
    task automatic do_reset();
        chipselect = 1'b0;
        write_n    = 1'b1;
        reset_n    = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Called 1ns after an edge; the write lands on the next edge and returns 1ns after it.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] exp_rd [4];
        exp_rd = '{32'h0, 32'h004C_4B40, 32'h0, 32'h0};
        reset_n = 1'b0;
        #3;
        n_checks++;
        if (out_port !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_out_async: got %h want %h", out_port, 18'h0);
        end
        do_reset();
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd);
            n_checks++;
            if (rd !== exp_rd[a]) begin
                n_fail++;
                $display("FAIL reset_read addr%0d: got %h want %h", a, rd, exp_rd[a]);
            end
        end
        n_checks++;
        if (out_port !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_out: got %h want %h", out_port, 18'h0);
        end
`ifdef LED_SEQ_IRQ_EN
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq: got %b want 0", irq);
        end
`endif
    endtask

    task automatic test_rotate_left();
        logic [31:0] rd;
        logic [17:0] e;
        do_reset();
        bus_write(2'd0, 32'h0000_0001);
        bus_write(2'd1, 32'd4);
        bus_write(2'd2, 32'h3);
        for (int k = 1; k <= 72; k++) exp_q.push_back(rotl(18'h00001, k / 4));
        for (int k = 1; exp_q.size() > 0; k++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (out_port !== e) begin
                n_fail++;
                $display("FAIL rotl_out cycle%0d: got %h want %h", k, out_port, e);
            end
        end
        bus_read(2'd3, rd);
        n_checks++;
        if (rd[31:16] !== 16'd18 || rd[0] !== 1'b1 || rd[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL rotl_status: got %h want cnt=18 step=1 running=1", rd);
        end
        bus_write(2'd2, 32'h0);
    endtask

    task automatic test_rotate_right();
        logic [31:0] rd;
        logic [17:0] e;
        do_reset();
        bus_write(2'd0, 32'h0002_0000);
        bus_write(2'd1, 32'd0);
        bus_read(2'd1, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL rotr_period_read: got %h want 0", rd);
        end
        bus_write(2'd2, 32'h5);
        for (int k = 1; k <= 18; k++) exp_q.push_back(rotr(18'h20000, k));
        for (int k = 1; exp_q.size() > 0; k++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (out_port !== e) begin
                n_fail++;
                $display("FAIL rotr_out cycle%0d: got %h want %h", k, out_port, e);
            end
        end
        bus_write(2'd2, 32'h0);
    endtask

    task automatic test_blink();
        logic [31:0] rd;
        logic [17:0] e;
        do_reset();
        bus_write(2'd0, 32'h0003_FFFF);
        bus_write(2'd1, 32'd2);
        bus_write(2'd2, 32'h7);
        for (int k = 1; k <= 6; k++) exp_q.push_back(((k / 2) % 2 == 1) ? 18'h00000 : 18'h3FFFF);
        for (int k = 1; exp_q.size() > 0; k++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (out_port !== e) begin
                n_fail++;
                $display("FAIL blink_out cycle%0d: got %h want %h", k, out_port, e);
            end
        end
        bus_write(2'd2, 32'h0);
        n_checks++;
        if (out_port !== 18'h3FFFF) begin
            n_fail++;
            $display("FAIL blink_stop_out: got %h want %h", out_port, 18'h3FFFF);
        end
        bus_read(2'd3, rd);
        n_checks++;
        if (rd[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL blink_stop_running: got %b want 0", rd[0]);
        end
    endtask

    task automatic test_write_collision();
        logic [31:0] rd;
        do_reset();
        bus_write(2'd0, 32'h0000_0001);
        bus_write(2'd1, 32'd4);
        bus_write(2'd2, 32'h3);
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (out_port !== 18'h00002) begin
            n_fail++;
            $display("FAIL coll_first_step: got %h want %h", out_port, 18'h00002);
        end
        bus_write(2'd3, 32'h2);
        bus_read(2'd3, rd);
        n_checks++;
        if (rd[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_step_clear: got %b want 0", rd[1]);
        end
        repeat (2) @(posedge clk);
        #1;
        bus_write(2'd0, 32'h0000_0055);
        bus_read(2'd3, rd);
        n_checks++;
        if (out_port !== 18'h00055 || rd[1] !== 1'b0 || rd[31:16] !== 16'd1) begin
            n_fail++;
            $display("FAIL coll_write_wins: got out=%h status=%h want out=00055 step=0 cnt=1", out_port, rd);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_port !== 18'h00055) begin
            n_fail++;
            $display("FAIL coll_no_early_step: got %h want %h", out_port, 18'h00055);
        end
        @(posedge clk);
        #1;
        bus_read(2'd3, rd);
        n_checks++;
        if (out_port !== 18'h000AA || rd[1] !== 1'b1 || rd[31:16] !== 16'd2) begin
            n_fail++;
            $display("FAIL coll_next_step: got out=%h status=%h want out=000aa step=1 cnt=2", out_port, rd);
        end
        bus_write(2'd2, 32'h0);
    endtask

    task automatic test_mode_change();
        logic [17:0] e;
        do_reset();
        bus_write(2'd0, 32'h0000_0001);
        bus_write(2'd1, 32'd4);
        bus_write(2'd2, 32'h3);
        @(posedge clk);
        #1;
        bus_write(2'd2, 32'h5);
        exp_q.push_back(18'h00001);
        exp_q.push_back(18'h20000);
        for (int k = 1; exp_q.size() > 0; k++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (out_port !== e) begin
                n_fail++;
                $display("FAIL mode_change cycle%0d: got %h want %h", k, out_port, e);
            end
        end
        bus_write(2'd2, 32'h0);
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] rd;
        do_reset();
        bus_write(2'd0, 32'h0000_0003);
        bus_write(2'd1, 32'd4);
        bus_write(2'd2, 32'h3);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        bus_read(2'd3, rd);
        n_checks++;
        if (out_port !== 18'h0 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL midrun_reset: got out=%h status=%h want 0/0", out_port, rd);
        end
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus_read(2'd3, rd);
        n_checks++;
        if (out_port !== 18'h0 || rd[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_idle: got out=%h running=%b want 0/0", out_port, rd[0]);
        end
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        do_reset();
`ifdef LED_SEQ_IRQ_EN
        bus_write(2'd1, 32'd3);
        bus_write(2'd2, 32'h9);
        bus_read(2'd2, rd);
        n_checks++;
        if (rd !== 32'h9 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_start: got control=%h irq=%b want 9/0", rd, irq);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_early: got %b want 0", irq);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_rise: got %b want 1", irq);
        end
        repeat (2) @(posedge clk);
        #1;
        bus_write(2'd3, 32'h2);
        bus_read(2'd3, rd);
        n_checks++;
        if (irq !== 1'b1 || rd[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_set_wins: got irq=%b step=%b want 1/1", irq, rd[1]);
        end
        bus_write(2'd3, 32'h2);
        bus_read(2'd3, rd);
        n_checks++;
        if (irq !== 1'b0 || rd[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_clear: got irq=%b step=%b want 0/0", irq, rd[1]);
        end
        bus_write(2'd2, 32'h0);
`else
        bus_write(2'd2, 32'h8);
        bus_read(2'd2, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL irq_en_unstored: got %h want 0", rd);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_rotate_left();
        test_rotate_right();
        test_blink();
        test_write_collision();
        test_mode_change();
        test_reset_mid_run();
        test_irq();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter LED_W, 18, width of the LED output and pattern register.
REQ-002 Parameter CNT_W, 24, width of the step-period prescaler.
REQ-003 Parameter PERIOD_RST, 24'd5000000, reset value of the PERIOD register.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 address  input  2  Avalon-MM slave word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  combinational read data, zero wait states; unused bits read 0.
REQ-011 out_port  output  LED_W  LED drive, registered.
REQ-012 irq  output  1  step interrupt; present only when LED_SEQ_IRQ_EN is defined.

Function
REQ-013 A write occurs in a cycle when chipselect=1 and write_n=0; the register updates on that clock edge.
REQ-014 addr0 PATTERN [LED_W-1:0] RW; the write also clears the prescaler and the blink phase.
REQ-015 addr1 PERIOD [CNT_W-1:0] RW; a value of 0 behaves as 1; the write clears the prescaler.
REQ-016 addr2 CONTROL: bit0 RUN; bits[2:1] MODE (00 static, 01 rotate-left, 10 rotate-right, 11 blink); bit3 IRQ_EN; all RW.
REQ-017 addr3 STATUS: bit0 RUNNING (RO); bit1 STEP (sticky, write-1-to-clear); bits[31:16] STEP_CNT (RO, wraps 0xFFFF->0).
REQ-018 FSM has two states, IDLE and RUN; IDLE->RUN on the edge where RUN becomes 1; RUN->IDLE on the edge where RUN becomes 0.
REQ-019 Entering IDLE clears the prescaler and the blink phase.
REQ-020 In RUN, the prescaler increments every cycle; a step fires in the cycle the prescaler equals max(PERIOD,1)-1, and the prescaler then returns to 0.
REQ-021 Step actions: rotate-left moves the pattern MSB into bit0; rotate-right moves bit0 into the MSB; blink toggles the phase; static leaves the pattern unchanged but still counts the step.
REQ-022 Each step sets STEP and increments STEP_CNT.
REQ-023 out_port = phase ? 0 : pattern in blink mode, otherwise pattern; it updates on the edge following the step or write.
REQ-024 A PATTERN or PERIOD write in the same cycle as a step wins: no step action, no STEP set, prescaler cleared.
REQ-025 A STEP clear in the same cycle as a step: set wins, STEP stays 1.
REQ-026 A MODE change while running takes effect at the next step; the prescaler is not cleared.
REQ-027 In IDLE, out_port holds the current pattern with phase 0.

Reset
REQ-028 On reset_n=0, immediately and without a clock: PATTERN=0, PERIOD=PERIOD_RST, CONTROL=0, STEP=0, STEP_CNT=0, prescaler=0, phase=0, FSM=IDLE, out_port=0, irq=0.
REQ-029 A reset mid-run abandons the pending step; the FSM is in IDLE at the first edge after release.

Configuration
REQ-030 With LED_SEQ_IRQ_EN defined: irq = STEP & IRQ_EN, registered from the same state, deasserted by a STEP clear or by IRQ_EN=0.
REQ-031 With LED_SEQ_IRQ_EN undefined: no irq port; CONTROL bit3 is not stored and reads 0; all other behaviour is identical.

Verification
REQ-032 Reset, then read all addresses -> 0x0, 0x4C4B40, 0x0, 0x0; out_port=0.
REQ-033 PATTERN=0x00001, PERIOD=4, CONTROL=0x3 (run, rotate-left) -> out_port=0x00002 four cycles after the start; after 18 steps it is 0x00001 and STEP_CNT=18.
REQ-034 PATTERN=0x20000, PERIOD=0, CONTROL=0x5 (run, rotate-right) -> one step per cycle: 0x10000, then 0x08000, and so on; after 18 cycles it is 0x20000.
REQ-035 PATTERN=0x3FFFF, PERIOD=2, CONTROL=0x7 (run, blink) -> out_port alternates 0x00000 and 0x3FFFF every 2 cycles; writing CONTROL=0 -> out_port=0x3FFFF, RUNNING=0.
REQ-036 Write PATTERN=0x00055 in the exact cycle a step is due -> out_port=0x00055, STEP unchanged, next step PERIOD cycles later.
REQ-037 With LED_SEQ_IRQ_EN: CONTROL=0x9, PERIOD=3 -> irq rises after the first step; write STATUS=0x2 in a step cycle -> STEP and irq stay 1; a clear in a non-step cycle -> irq=0 on the next edge.
